// File: rtl/lb_slot_pool_pkg.sv
// Shared definitions for the per-core free-slot descriptor pool.
// Holds default sizing, width-derivation helpers, the tag encoding and the
// err_flags bit positions. Optional feature macro: LB_SLOT_FREE_CHECK_EN.
package lb_slot_pool_pkg;

    localparam int DEF_CORE_COUNT = 8;
    localparam int DEF_SLOT_COUNT = 32;

    // Tag 0 never names a slot; valid tags run 1..SLOT_COUNT.
    localparam int NULL_TAG = 0;

    // err_flags bit positions
    localparam int ERR_POP      = 0;   // pop on empty/initialising pool, or LB/ic collision
    localparam int ERR_OVERFLOW = 1;   // free into a full pool
    localparam int ERR_BAD_FREE = 2;   // free of a tag that is not outstanding
    localparam int ERR_W        = 3;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } pool_state_e;

    // Width of an occupancy count, range 0..slots.
    function automatic int slot_width(input int slots);
        return $clog2(slots + 1);
    endfunction

    // Tags carry at least 5 bits so descriptors keep a stable layout on small pools.
    function automatic int tag_width(input int slots);
        return ($clog2(slots + 1) > 5) ? $clog2(slots + 1) : 5;
    endfunction

    function automatic int core_id_width(input int cores);
        return (cores > 1) ? $clog2(cores) : 1;
    endfunction

endpackage

// File: rtl/lb_slot_pool_if.sv
// Balancer / inter-core / free-return bus of the slot pool.
// master: the environment (balancer, requesting cores, returning cores).
// slave:  the slot pool itself.
interface lb_slot_pool_if
    import lb_slot_pool_pkg::*;
#(
    parameter int CORE_COUNT = DEF_CORE_COUNT,
    parameter int SLOT_COUNT = DEF_SLOT_COUNT
);
    localparam int SLOT_WIDTH    = slot_width(SLOT_COUNT);
    localparam int TAG_WIDTH     = tag_width(SLOT_COUNT);
    localparam int CORE_ID_WIDTH = core_id_width(CORE_COUNT);
    localparam int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH;

    logic [CORE_COUNT-1:0]            slots_flush;
    logic [CORE_ID_WIDTH-1:0]         selected_core;
    logic                             desc_pop;
    logic [ID_TAG_WIDTH-1:0]          desc_data;
    logic                             ic_req_valid;
    logic [CORE_ID_WIDTH-1:0]         ic_req_core;
    logic                             ic_req_ready;
    logic [ID_TAG_WIDTH-1:0]          ic_desc;
    logic                             free_valid;
    logic [CORE_ID_WIDTH-1:0]         free_core;
    logic [TAG_WIDTH-1:0]             free_tag;
    logic [CORE_COUNT*SLOT_WIDTH-1:0] slot_counts;
    logic [CORE_COUNT-1:0]            slot_valids;
    logic [CORE_COUNT-1:0]            slots_busy;
    logic [ERR_W-1:0]                 err_flags;

    modport master (
        output slots_flush, selected_core, desc_pop,
               ic_req_valid, ic_req_core,
               free_valid, free_core, free_tag,
        input  desc_data, ic_req_ready, ic_desc,
               slot_counts, slot_valids, slots_busy, err_flags
    );

    modport slave (
        input  slots_flush, selected_core, desc_pop,
               ic_req_valid, ic_req_core,
               free_valid, free_core, free_tag,
        output desc_data, ic_req_ready, ic_desc,
               slot_counts, slot_valids, slots_busy, err_flags
    );

endinterface

// File: rtl/lb_slot_pool_fifo.sv
// One free-slot pool: tag RAM, head/tail pointers, occupancy count and the
// INIT->READY fill sequencer. With LB_SLOT_FREE_CHECK_EN defined, an
// outstanding-tag bitmap rejects frees of tags the pool never handed out.
module lb_slot_pool_fifo
    import lb_slot_pool_pkg::*;
#(
    parameter int SLOT_COUNT = DEF_SLOT_COUNT,
    parameter int SLOT_WIDTH = slot_width(DEF_SLOT_COUNT),
    parameter int TAG_WIDTH  = tag_width(DEF_SLOT_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pop,
    input  logic                  free_valid,
    input  logic [TAG_WIDTH-1:0]  free_tag,
    output logic [TAG_WIDTH-1:0]  head_tag,
    output logic [SLOT_WIDTH-1:0] count,
    output logic                  valid,
    output logic                  pop_err,
    output logic                  full_err,
    output logic                  bad_err
);
    localparam int PTR_W = $clog2(SLOT_COUNT);
    localparam logic [SLOT_WIDTH-1:0] FULL_CNT = SLOT_WIDTH'(SLOT_COUNT);
    localparam logic [TAG_WIDTH-1:0]  LAST_TAG = TAG_WIDTH'(SLOT_COUNT);
    localparam logic [TAG_WIDTH-1:0]  TAG_ONE  = TAG_WIDTH'(1);

    pool_state_e          state;
    logic [TAG_WIDTH-1:0] fill_tag;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [TAG_WIDTH-1:0] ram [SLOT_COUNT];

    logic full;
    logic tag_ok;
    logic do_pop;
    logic do_free;
    logic init_wr;

    assign head_tag = ram[head];
    assign valid    = (state == ST_READY) && (count != '0);
    assign full     = (count == FULL_CNT);
    assign init_wr  = (state == ST_INIT) && !rst && !flush;

    // Accepted pops/frees; a flush in the same cycle discards the pool anyway.
    assign do_pop   = pop && valid && !flush;
    assign do_free  = free_valid && (state == ST_READY) && tag_ok && !full && !flush;

    // Frees to an initialising pool are dropped without raising an error.
    assign pop_err  = pop && !valid;
    assign full_err = free_valid && (state == ST_READY) && tag_ok && full && !flush;
    assign bad_err  = free_valid && (state == ST_READY) && !tag_ok && !flush;

`ifdef LB_SLOT_FREE_CHECK_EN
    logic [SLOT_COUNT-1:0] outstanding;
    logic [PTR_W-1:0]      head_idx;
    logic [PTR_W-1:0]      free_idx;

    assign head_idx = PTR_W'(head_tag - TAG_ONE);
    assign free_idx = PTR_W'(free_tag - TAG_ONE);
    assign tag_ok   = (free_tag != TAG_WIDTH'(NULL_TAG)) && (free_tag <= LAST_TAG)
                      && outstanding[free_idx];

    // Track tags handed out and not yet returned; wiped whenever the pool refills.
    always_ff @(posedge clk) begin
        if (rst || flush || state == ST_INIT) begin
            outstanding <= '0;
        end else begin
            if (do_pop)  outstanding[head_idx] <= 1'b1;
            if (do_free) outstanding[free_idx] <= 1'b0;
        end
    end
`else
    assign tag_ok = 1'b1;
`endif

    // Pool FSM: fill tags 1..SLOT_COUNT one per cycle, then serve pops and frees.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= ST_INIT;
            fill_tag <= TAG_ONE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    tail     <= tail + PTR_W'(1);
                    count    <= count + SLOT_WIDTH'(1);
                    fill_tag <= fill_tag + TAG_ONE;
                    if (fill_tag == LAST_TAG) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (do_pop)  head <= head + PTR_W'(1);
                    if (do_free) tail <= tail + PTR_W'(1);
                    count <= count + SLOT_WIDTH'(do_free) - SLOT_WIDTH'(do_pop);
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Tag storage: fill pattern during INIT, returned tags at the tail afterwards.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            ram[tail] <= fill_tag;
        end else if (do_free) begin
            ram[tail] <= free_tag;
        end
    end

endmodule

// File: rtl/lb_slot_pool.sv
// Per-core free-slot descriptor pool feeding the hash load balancer.
// Demuxes balancer pops, inter-core pops and slot returns onto CORE_COUNT
// pools, resolves LB/ic collisions in favour of the inter-core port, and
// muxes the head tags onto desc_data / ic_desc.
// Optional feature macro: LB_SLOT_FREE_CHECK_EN (outstanding-tag free check).
module lb_slot_pool
    import lb_slot_pool_pkg::*;
#(
    parameter int CORE_COUNT = DEF_CORE_COUNT,
    parameter int SLOT_COUNT = DEF_SLOT_COUNT
) (
    input  logic           clk,
    input  logic           rst,
    lb_slot_pool_if.slave  bus
);
    localparam int SLOT_WIDTH    = slot_width(SLOT_COUNT);
    localparam int TAG_WIDTH     = tag_width(SLOT_COUNT);
    localparam int CORE_ID_WIDTH = core_id_width(CORE_COUNT);

    logic [TAG_WIDTH-1:0]  head_tag   [CORE_COUNT];
    logic [SLOT_WIDTH-1:0] pool_count [CORE_COUNT];
    logic [CORE_COUNT-1:0] valid;
    logic [CORE_COUNT-1:0] busy;
    logic [CORE_COUNT-1:0] pop_req;
    logic [CORE_COUNT-1:0] free_req;
    logic [CORE_COUNT-1:0] pop_err;
    logic [CORE_COUNT-1:0] full_err;
    logic [CORE_COUNT-1:0] bad_err;
    logic [CORE_COUNT*SLOT_WIDTH-1:0] counts_flat;
    logic                  ic_pop;
    logic                  collision;
    logic [ERR_W-1:0]      err_q;

    assign ic_pop    = bus.ic_req_valid && valid[bus.ic_req_core];
    assign collision = bus.desc_pop && busy[bus.selected_core];

    // Per-core demux of busy, pop and free requests; the ic port wins a collision.
    always_comb begin
        busy     = '0;
        pop_req  = '0;
        free_req = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            busy[c]     = bus.ic_req_valid && (bus.ic_req_core == CORE_ID_WIDTH'(c));
            pop_req[c]  = (ic_pop && (bus.ic_req_core == CORE_ID_WIDTH'(c)))
                          || (bus.desc_pop && !collision
                              && (bus.selected_core == CORE_ID_WIDTH'(c)));
            free_req[c] = bus.free_valid && (bus.free_core == CORE_ID_WIDTH'(c));
        end
    end

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_pool
        lb_slot_pool_fifo #(
            .SLOT_COUNT (SLOT_COUNT),
            .SLOT_WIDTH (SLOT_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (bus.slots_flush[g]),
            .pop        (pop_req[g]),
            .free_valid (free_req[g]),
            .free_tag   (bus.free_tag),
            .head_tag   (head_tag[g]),
            .count      (pool_count[g]),
            .valid      (valid[g]),
            .pop_err    (pop_err[g]),
            .full_err   (full_err[g]),
            .bad_err    (bad_err[g])
        );
    end

    // Flatten the per-pool counts onto the status bus.
    always_comb begin
        counts_flat = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            counts_flat[c*SLOT_WIDTH +: SLOT_WIDTH] = pool_count[c];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (collision || (|pop_err)) err_q[ERR_POP]      <= 1'b1;
            if (|full_err)               err_q[ERR_OVERFLOW] <= 1'b1;
            if (|bad_err)                err_q[ERR_BAD_FREE] <= 1'b1;
        end
    end

    assign bus.desc_data    = {bus.selected_core, head_tag[bus.selected_core]};
    assign bus.ic_desc      = {bus.ic_req_core, head_tag[bus.ic_req_core]};
    assign bus.ic_req_ready = valid[bus.ic_req_core];
    assign bus.slots_busy   = busy;
    assign bus.slot_valids  = valid;
    assign bus.slot_counts  = counts_flat;
    assign bus.err_flags    = err_q;

endmodule

// File: tb/tb_lb_slot_pool.sv
// Self-checking bench for lb_slot_pool. A per-core reference pool model
// predicts every descriptor; expected descriptors go into a scoreboard queue
// when a pop is driven and are compared when the DUT presents them.
module tb_lb_slot_pool;
    localparam int NC = 8;
    localparam int NS = 32;
    localparam int SW = 6;
    localparam int TW = 6;
    localparam int CW = 3;

    logic clk;
    logic rst;

    lb_slot_pool_if bus ();

    lb_slot_pool dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [TW-1:0]    model [NC][$];
    logic [CW+TW-1:0] exp_q [$];

    function automatic logic [SW-1:0] cnt_of(input int c);
        logic [NC*SW-1:0] v;
        v = bus.slot_counts;
        return v[c*SW +: SW];
    endfunction

    task automatic clear_inputs();
        bus.slots_flush   = '0;
        bus.selected_core = '0;
        bus.desc_pop      = 1'b0;
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_core   = '0;
        bus.free_valid    = 1'b0;
        bus.free_core     = '0;
        bus.free_tag      = '0;
    endtask

    task automatic model_fill(input int c);
        model[c].delete();
        for (int t = 1; t <= NS; t++) model[c].push_back(TW'(t));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset and wait out the fill without checking anything.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (NS) next_cycle();
        for (int c = 0; c < NC; c++) model_fill(c);
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [CW+TW-1:0] exp;
        logic [TW-1:0]    t;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (bus.slot_counts !== '0) begin
                    n_bad++;
                    $display("FAIL reset_counts got %h want 0", bus.slot_counts);
                end
                n_cmp++;
                if (bus.err_flags !== 3'b000) begin
                    n_bad++;
                    $display("FAIL reset_err got %b want 000", bus.err_flags);
                end
            end
            n_cmp++;
            if (bus.slot_valids !== 8'h00) begin
                n_bad++;
                $display("FAIL init_valids cycle %0d got %h want 00", i + 1, bus.slot_valids);
            end
            next_cycle();
        end
        for (int c = 0; c < NC; c++) model_fill(c);
        @(negedge clk);
        n_cmp++;
        if (bus.slot_valids !== 8'hFF) begin
            n_bad++;
            $display("FAIL ready_valids got %h want FF", bus.slot_valids);
        end
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (cnt_of(c) !== SW'(NS)) begin
                n_bad++;
                $display("FAIL ready_count core %0d got %0d want %0d", c, cnt_of(c), NS);
            end
        end
        next_cycle();
        bus.selected_core = 3'd3;
        bus.desc_pop      = 1'b1;
        t = model[3].pop_front();
        exp_q.push_back({3'd3, t});
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.desc_data !== exp) begin
            n_bad++;
            $display("FAIL first_pop got %h want %h", bus.desc_data, exp);
        end
        next_cycle();
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(3) !== SW'(NS - 1)) begin
            n_bad++;
            $display("FAIL first_pop_count got %0d want %0d", cnt_of(3), NS - 1);
        end
        next_cycle();
    endtask

    task automatic test_drain();
        logic [CW+TW-1:0] exp;
        logic [TW-1:0]    t;
        bus.selected_core = 3'd0;
        for (int i = 0; i < NS; i++) begin
            bus.desc_pop = 1'b1;
            t = model[0].pop_front();
            exp_q.push_back({3'd0, t});
            @(negedge clk);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.desc_data !== exp) begin
                n_bad++;
                $display("FAIL drain_tag pop %0d got %h want %h", i, bus.desc_data, exp);
            end
            next_cycle();
        end
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(0) !== '0 || bus.slot_valids[0] !== 1'b0 || bus.err_flags !== 3'b000) begin
            n_bad++;
            $display("FAIL drain_empty count %0d valid %b err %b want 0 0 000",
                     cnt_of(0), bus.slot_valids[0], bus.err_flags);
        end
        next_cycle();
        bus.desc_pop = 1'b1;
        next_cycle();
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(0) !== '0 || bus.err_flags[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_pop count %0d err0 %b want 0 1", cnt_of(0), bus.err_flags[0]);
        end
        next_cycle();
    endtask

    task automatic test_free_pop_same();
        logic [CW+TW-1:0] exp;
        logic [TW-1:0]    t;
        bus.selected_core = 3'd2;
        for (int i = 0; i < NS - 5; i++) begin
            bus.desc_pop = 1'b1;
            t = model[2].pop_front();
            exp_q.push_back({3'd2, t});
            @(negedge clk);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.desc_data !== exp) begin
                n_bad++;
                $display("FAIL core2_pop %0d got %h want %h", i, bus.desc_data, exp);
            end
            next_cycle();
        end
        bus.free_valid = 1'b1;
        bus.free_core  = 3'd2;
        bus.free_tag   = 6'd7;
        t = model[2].pop_front();
        exp_q.push_back({3'd2, t});
        model[2].push_back(6'd7);
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.desc_data !== exp) begin
            n_bad++;
            $display("FAIL free_pop_tag got %h want %h", bus.desc_data, exp);
        end
        next_cycle();
        bus.free_valid = 1'b0;
        bus.desc_pop   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(2) !== SW'(5)) begin
            n_bad++;
            $display("FAIL free_pop_count got %0d want 5", cnt_of(2));
        end
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            bus.desc_pop = 1'b1;
            t = model[2].pop_front();
            exp_q.push_back({3'd2, t});
            @(negedge clk);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.desc_data !== exp) begin
                n_bad++;
                $display("FAIL core2_tail %0d got %h want %h", i, bus.desc_data, exp);
            end
            next_cycle();
        end
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(2) !== '0) begin
            n_bad++;
            $display("FAIL core2_final_count got %0d want 0", cnt_of(2));
        end
        next_cycle();
    endtask

    task automatic test_collision();
        logic [CW+TW-1:0] exp;
        logic [TW-1:0]    t;
        do_reset();
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_core   = 3'd4;
        bus.selected_core = 3'd4;
        bus.desc_pop      = 1'b1;
        t = model[4].pop_front();
        exp_q.push_back({3'd4, t});
        @(negedge clk);
        n_cmp++;
        if (bus.slots_busy !== 8'h10 || bus.ic_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_busy got %h ready %b want 10 1", bus.slots_busy, bus.ic_req_ready);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.ic_desc !== exp) begin
            n_bad++;
            $display("FAIL coll_ic_desc got %h want %h", bus.ic_desc, exp);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (cnt_of(4) !== SW'(NS - 1) || bus.err_flags !== 3'b001) begin
            n_bad++;
            $display("FAIL coll_after count %0d err %b want %0d 001", cnt_of(4), bus.err_flags, NS - 1);
        end
        next_cycle();
        bus.selected_core = 3'd4;
        bus.desc_pop      = 1'b1;
        t = model[4].pop_front();
        exp_q.push_back({3'd4, t});
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.desc_data !== exp) begin
            n_bad++;
            $display("FAIL coll_next_lb got %h want %h", bus.desc_data, exp);
        end
        next_cycle();
        // Independent ic and LB pops on different cores in one cycle.
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_core   = 3'd5;
        bus.selected_core = 3'd6;
        bus.desc_pop      = 1'b1;
        t = model[5].pop_front();
        exp_q.push_back({3'd5, t});
        t = model[6].pop_front();
        exp_q.push_back({3'd6, t});
        @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.ic_desc !== exp || bus.slots_busy !== 8'h20) begin
            n_bad++;
            $display("FAIL dual_ic got %h busy %h want %h 20", bus.ic_desc, bus.slots_busy, exp);
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (bus.desc_data !== exp) begin
            n_bad++;
            $display("FAIL dual_lb got %h want %h", bus.desc_data, exp);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (cnt_of(5) !== SW'(NS - 1) || cnt_of(6) !== SW'(NS - 1) || cnt_of(4) !== SW'(NS - 2)) begin
            n_bad++;
            $display("FAIL dual_counts got %0d %0d %0d want %0d %0d %0d",
                     cnt_of(4), cnt_of(5), cnt_of(6), NS - 2, NS - 1, NS - 1);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        logic [CW+TW-1:0] exp;
        logic [TW-1:0]    t;
        do_reset();
        bus.selected_core = 3'd1;
        for (int i = 0; i < NS - 10; i++) begin
            bus.desc_pop = 1'b1;
            t = model[1].pop_front();
            next_cycle();
        end
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(1) !== SW'(10)) begin
            n_bad++;
            $display("FAIL pre_flush_count got %0d want 10", cnt_of(1));
        end
        bus.slots_flush = 8'h02;
        next_cycle();
        bus.slots_flush = 8'h00;
        next_cycle();
        bus.free_valid = 1'b1;
        bus.free_core  = 3'd1;
        bus.free_tag   = 6'd5;
        next_cycle();
        bus.free_valid = 1'b0;
        repeat (NS - 3) next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.slot_valids[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_early_valid got %b want 0", bus.slot_valids[1]);
        end
        next_cycle();
        model_fill(1);
        @(negedge clk);
        n_cmp++;
        if (bus.slot_valids[1] !== 1'b1 || cnt_of(1) !== SW'(NS)) begin
            n_bad++;
            $display("FAIL flush_refill valid %b count %0d want 1 %0d", bus.slot_valids[1], cnt_of(1), NS);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.desc_pop = 1'b1;
            t = model[1].pop_front();
            exp_q.push_back({3'd1, t});
            @(negedge clk);
            exp = exp_q.pop_front();
            n_cmp++;
            if (bus.desc_data !== exp) begin
                n_bad++;
                $display("FAIL flush_tag %0d got %h want %h", i, bus.desc_data, exp);
            end
            next_cycle();
        end
        bus.desc_pop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(1) !== SW'(NS - 3) || bus.err_flags !== 3'b000) begin
            n_bad++;
            $display("FAIL flush_after count %0d err %b want %0d 000", cnt_of(1), bus.err_flags, NS - 3);
        end
        next_cycle();
    endtask

    task automatic test_bad_free();
        logic [2:0] exp_err;
`ifdef LB_SLOT_FREE_CHECK_EN
        exp_err = 3'b100;
`else
        exp_err = 3'b010;
`endif
        bus.free_valid = 1'b1;
        bus.free_core  = 3'd6;
        bus.free_tag   = 6'd9;
        next_cycle();
        bus.free_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cnt_of(6) !== SW'(NS) || bus.err_flags !== exp_err) begin
            n_bad++;
            $display("FAIL full_free count %0d err %b want %0d %b", cnt_of(6), bus.err_flags, NS, exp_err);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_drain();
        test_free_pop_same();
        test_collision();
        test_flush();
        test_bad_free();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
